// File: rtl/fft_bfly2_sdf_if.sv
// Stream, delay-line and output bundle for the radix-2 SDF butterfly controller.
// The slave side is the controller; the master side is its environment.
interface fft_bfly2_sdf_if #(
    parameter int DATA_WIDTH = 9
);
    localparam int DW = DATA_WIDTH;

    logic                din_valid;
    logic                flush;
    logic [15:0][DW-1:0] din_i;
    logic [15:0][DW-1:0] din_q;
    logic [15:0][DW:0]   dly_i;
    logic [15:0][DW:0]   dly_q;
    logic                sr_valid;
    logic [15:0][DW:0]   sr_i;
    logic [15:0][DW:0]   sr_q;
    logic                dout_valid;
    logic [15:0][DW:0]   dout_i;
    logic [15:0][DW:0]   dout_q;
    logic                phase;

    modport master (
        output din_valid, flush, din_i, din_q, dly_i, dly_q,
        input  sr_valid, sr_i, sr_q, dout_valid, dout_i, dout_q, phase
    );

    modport slave (
        input  din_valid, flush, din_i, din_q, dly_i, dly_q,
        output sr_valid, sr_i, sr_q, dout_valid, dout_i, dout_q, phase
    );
endinterface

// File: rtl/fft_bfly2_sdf_ctrl.sv
// Radix-2 single-delay-feedback butterfly in front of a 16-lane delay line of DEPTH samples.
//  state  | meaning
//  S_FILL | first half of frame: push samples, emit pending differences
//  S_BFLY | second half: emit sums, push differences back into the delay line
module fft_bfly2_sdf_ctrl #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 256
) (
    input  logic               clk,
    input  logic               rstn,
    fft_bfly2_sdf_if.slave     bus
);
    localparam int DW  = DATA_WIDTH;
    localparam int BLK = DEPTH / 16;
    localparam int CW  = $clog2(BLK);
    localparam logic [CW-1:0] LAST = CW'(BLK - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_BFLY = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt_left, cnt_left_nxt;
    logic              pend, pend_nxt;
    logic              flush_beat;
    logic              beat;
    logic              tc;
    logic [15:0][DW:0] din_sx_i, din_sx_q;
    logic [15:0][DW:0] sum_i, sum_q;
    logic [15:0][DW:0] diff_i, diff_q;

    // A flush beat stands in for a zero sample, so din is gated to zero when not valid.
    always_comb begin
        din_sx_i = '0;
        din_sx_q = '0;
        sum_i    = '0;
        sum_q    = '0;
        diff_i   = '0;
        diff_q   = '0;
        for (int l = 0; l < 16; l++) begin
            if (bus.din_valid) begin
                din_sx_i[l] = {bus.din_i[l][DW-1], bus.din_i[l]};
                din_sx_q[l] = {bus.din_q[l][DW-1], bus.din_q[l]};
            end
            sum_i[l]  = bus.dly_i[l] + din_sx_i[l];
            sum_q[l]  = bus.dly_q[l] + din_sx_q[l];
            diff_i[l] = bus.dly_i[l] - din_sx_i[l];
            diff_q[l] = bus.dly_q[l] - din_sx_q[l];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_FILL;
            cnt_left <= LAST;
            pend     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_left <= cnt_left_nxt;
            pend     <= pend_nxt;
        end
    end

    // cnt_left counts down the beats remaining in the current half; tc marks its last beat.
    always_comb begin
        state_nxt    = state;
        cnt_left_nxt = cnt_left;
        pend_nxt     = pend;
        flush_beat   = (state == S_FILL) && bus.flush && !bus.din_valid && pend;
        beat         = bus.din_valid || flush_beat;
        tc           = (cnt_left == '0);
        if (beat) begin
            if (tc) begin
                cnt_left_nxt = LAST;
                state_nxt    = (state == S_FILL) ? S_BFLY : S_FILL;
                pend_nxt     = (state == S_BFLY);
            end else begin
                cnt_left_nxt = cnt_left - 1'b1;
            end
        end
    end

    always_comb begin
        bus.phase = (state == S_BFLY);
        if (state == S_BFLY) begin
            bus.sr_valid = bus.din_valid;
            bus.sr_i     = diff_i;
            bus.sr_q     = diff_q;
        end else begin
            bus.sr_valid = beat;
            bus.sr_i     = din_sx_i;
            bus.sr_q     = din_sx_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.dout_valid <= 1'b0;
            bus.dout_i     <= '0;
            bus.dout_q     <= '0;
        end else begin
            bus.dout_valid <= 1'b0;
            if (beat && state == S_BFLY) begin
                bus.dout_valid <= 1'b1;
                bus.dout_i     <= sum_i;
                bus.dout_q     <= sum_q;
            end else if (beat && pend) begin
                bus.dout_valid <= 1'b1;
                bus.dout_i     <= bus.dly_i;
                bus.dout_q     <= bus.dly_q;
            end
        end
    end
endmodule

// File: tb/tb_fft_bfly2_sdf_ctrl.sv
// Bench for fft_bfly2_sdf_ctrl: frame-level reference model, scoreboard queue, delay-line model.
module tb_fft_bfly2_sdf_ctrl;
    localparam int DW    = 9;
    localparam int W     = DW + 1;
    localparam int DEPTH = 32;
    localparam int BLK   = DEPTH / 16;

    typedef struct packed {
        logic [15:0][W-1:0] i;
        logic [15:0][W-1:0] q;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fft_bfly2_sdf_if #(.DATA_WIDTH(DW)) bus ();

    fft_bfly2_sdf_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Delay line of BLK beats, shifting on sr_valid, cleared by rstn.
    int dl_i [BLK][16];
    int dl_q [BLK][16];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < BLK; b++)
                for (int l = 0; l < 16; l++) begin
                    dl_i[b][l] <= 0;
                    dl_q[b][l] <= 0;
                end
        end else if (bus.sr_valid) begin
            for (int l = 0; l < 16; l++) begin
                for (int b = BLK - 1; b > 0; b--) begin
                    dl_i[b][l] <= dl_i[b-1][l];
                    dl_q[b][l] <= dl_q[b-1][l];
                end
                dl_i[0][l] <= int'($signed(bus.sr_i[l]));
                dl_q[0][l] <= int'($signed(bus.sr_q[l]));
            end
        end
    end

    always_comb begin
        for (int l = 0; l < 16; l++) begin
            bus.dly_i[l] = W'(dl_i[BLK-1][l]);
            bus.dly_q[l] = W'(dl_q[BLK-1][l]);
        end
    end

    // Reference model: position in frame, saved first-half samples, pending differences.
    int    pos;
    bit    pend_m;
    int    first_i [BLK][16];
    int    first_q [BLK][16];
    int    diff_i  [BLK][16];
    int    diff_q  [BLK][16];
    beat_t exp_q [$];
    int    xi [16];
    int    xq [16];

    function automatic void model_clear();
        pos    = 0;
        pend_m = 1'b0;
        exp_q.delete();
    endfunction

    task automatic set_all(input int a, input int b);
        for (int l = 0; l < 16; l++) begin
            xi[l] = a;
            xq[l] = b;
        end
    endtask

    task automatic set_rand();
        for (int l = 0; l < 16; l++) begin
            xi[l] = int'($urandom_range(0, 511)) - 256;
            xq[l] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    task automatic step(input bit v, input bit f);
        bit    in_fill, mbeat, e_srv;
        int    si, sq, k;
        beat_t e_sr, e_out;
        @(negedge clk);
        bus.din_valid = v;
        bus.flush     = f;
        for (int l = 0; l < 16; l++) begin
            bus.din_i[l] = DW'(xi[l]);
            bus.din_q[l] = DW'(xq[l]);
        end
        #1;
        in_fill = (pos < BLK);
        mbeat   = v || (in_fill && f && pend_m);
        e_srv   = in_fill ? mbeat : v;
        k       = in_fill ? pos : pos - BLK;
        total++;
        if (bus.phase !== !in_fill) begin
            bad++;
            $display("FAIL phase: got %0b want %0b (pos %0d)", bus.phase, !in_fill, pos);
        end
        total++;
        if (bus.sr_valid !== e_srv) begin
            bad++;
            $display("FAIL sr_valid: got %0b want %0b (pos %0d)", bus.sr_valid, e_srv, pos);
        end
        if (e_srv) begin
            for (int l = 0; l < 16; l++) begin
                si = v ? xi[l] : 0;
                sq = v ? xq[l] : 0;
                e_sr.i[l] = in_fill ? W'(si) : W'(first_i[k][l] - si);
                e_sr.q[l] = in_fill ? W'(sq) : W'(first_q[k][l] - sq);
            end
            total++;
            if (bus.sr_i !== e_sr.i || bus.sr_q !== e_sr.q) begin
                bad++;
                $display("FAIL sr_data: got i=%h q=%h want i=%h q=%h", bus.sr_i, bus.sr_q, e_sr.i, e_sr.q);
            end
        end
        if (mbeat) begin
            for (int l = 0; l < 16; l++) begin
                si = v ? xi[l] : 0;
                sq = v ? xq[l] : 0;
                if (in_fill) begin
                    e_out.i[l]     = W'(diff_i[k][l]);
                    e_out.q[l]     = W'(diff_q[k][l]);
                    first_i[k][l]  = si;
                    first_q[k][l]  = sq;
                end else begin
                    e_out.i[l]     = W'(first_i[k][l] + si);
                    e_out.q[l]     = W'(first_q[k][l] + sq);
                    diff_i[k][l]   = first_i[k][l] - si;
                    diff_q[k][l]   = first_q[k][l] - sq;
                end
            end
            if (!in_fill || pend_m) exp_q.push_back(e_out);
            if (pos == BLK - 1) pend_m = 1'b0;
            if (pos == 2 * BLK - 1) pend_m = 1'b1;
            pos = (pos + 1) % (2 * BLK);
        end
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.din_valid = 1'b0;
        bus.flush     = 1'b0;
        #1;
        model_clear();
        total++;
        if (bus.dout_valid !== 1'b0 || bus.phase !== 1'b0) begin
            bad++;
            $display("FAIL hard_reset: got valid=%0b phase=%0b want 0 0", bus.dout_valid, bus.phase);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: every presented output beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && bus.dout_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL dout_unexpected: got i=%h want no output", bus.dout_i);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.dout_i !== e.i || bus.dout_q !== e.q) begin
                        bad++;
                        $display("FAIL dout: got i=%h q=%h want i=%h q=%h", bus.dout_i, bus.dout_q, e.i, e.q);
                    end
                end
            end
        end
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.din_i     = '0;
        bus.din_q     = '0;
        model_clear();
        set_all(0, 0);
        #1;
        total++;
        if (bus.dout_valid !== 1'b0 || bus.dout_i !== '0 || bus.dout_q !== '0 || bus.phase !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got valid=%0b i=%h q=%h phase=%0b want all 0",
                     bus.dout_valid, bus.dout_i, bus.dout_q, bus.phase);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0);
        step(0, 1);
        step(0, 0);
        total++;
        if (bus.dout_i !== '0 || bus.dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got valid=%0b i=%h want 0 0", bus.dout_valid, bus.dout_i);
        end

        // Basic frame, then a second frame that drains its differences.
        for (int n = 1; n <= 8; n++) begin
            set_all(n, -n);
            step(1, 0);
        end

        // Extremes through the butterfly.
        set_all(-256, 255);  step(1, 0);
        set_all(255, -256);  step(1, 0);
        set_all(255, 255);   step(1, 0);
        set_all(255, -256);  step(1, 0);

        // Same frame with three-cycle gaps between beats, then flush to drain.
        for (int n = 1; n <= 4; n++) begin
            set_all(n, -n);
            step(1, 0);
            set_rand();
            for (int g = 0; g < 3; g++) step(0, 0);
        end
        set_rand();
        for (int g = 0; g < 3; g++) step(0, 1);

        // Reset during the first BFLY beat, then a fresh frame.
        hard_reset();
        set_all(1, 1); step(1, 0);
        set_all(2, 2); step(1, 0);
        @(negedge clk);
        set_all(3, 3);
        bus.din_valid = 1'b1;
        bus.din_i     = {16{DW'(3)}};
        rstn = 1'b0;
        #1;
        model_clear();
        total++;
        if (bus.dout_valid !== 1'b0 || bus.phase !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_frame: got valid=%0b phase=%0b want 0 0", bus.dout_valid, bus.phase);
        end
        @(negedge clk);
        rstn = 1'b1;
        bus.din_valid = 1'b0;
        for (int n = 5; n <= 8; n++) begin
            set_all(n, 2 * n);
            step(1, 0);
        end
        set_rand();
        step(0, 1);
        step(0, 1);

        // Random traffic with gaps and flushes, then drain.
        for (int c = 0; c < 400; c++) begin
            set_rand();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
        end
        set_rand();
        for (int c = 0; c < 2 * BLK + 2; c++) step(0, 1);
        for (int c = 0; c < 3; c++) step(0, 0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
